// File: rtl/gc_rotating_refresh_bank.sv
// gc_rotating_refresh_bank: N-bank gain-cell memory with a rotating copy-refresh sweep hidden behind one user port
module gc_rotating_refresh_bank #(
   parameter int DATA_W     = 64,
   parameter int DEPTH      = 128,
   parameter int NUM_BANKS  = 3,
   parameter int REF_PERIOD = 1024,
   localparam int ADDR_W    = $clog2(DEPTH),
   localparam int BANK_W    = $clog2(NUM_BANKS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              u_we,
   input  logic [ADDR_W-1:0] u_write_addr,
   input  logic [DATA_W-1:0] u_data_in,
   input  logic              u_re,
   input  logic [ADDR_W-1:0] u_read_addr,
   input  logic              ref_auto_en,
   input  logic              ref_req,
   output logic [DATA_W-1:0] rd,
   output logic              rd_valid,
   output logic              ref_busy,
   output logic              ref_done,
   output logic [BANK_W-1:0] active_bank,
   output logic [ADDR_W-1:0] sr_addr
);
   localparam int TMR_W = $clog2(REF_PERIOD + 1);

   typedef enum logic {S_IDLE, S_COPY} state_t;

   state_t            r_state, w_state_nx;
   logic [ADDR_W-1:0] r_sr, w_sr_nx;
   logic [TMR_W-1:0]  r_tmr, w_tmr_nx;
   logic              r_pend, w_pend_nx;
   logic [BANK_W-1:0] r_bank, w_bank_nx;
   logic              r_done, w_done_nx;
   logic [DATA_W-1:0] r_rd;
   logic              r_rd_valid;
   logic [DATA_W-1:0] r_mem [NUM_BANKS][DEPTH];

   logic [BANK_W-1:0] w_nxt, w_rbank;
   logic              w_copy, w_last, w_start, w_copy_wr;

   assign w_nxt     = (r_bank == BANK_W'(NUM_BANKS - 1)) ? '0 : r_bank + 1'b1;
   assign w_copy    = r_state == S_COPY;
   assign w_last    = w_copy && r_sr == ADDR_W'(DEPTH - 1);
   assign w_start   = !w_copy && ((ref_auto_en && r_tmr == TMR_W'(REF_PERIOD - 1)) || ref_req || r_pend);
   // a user write to the row being swept replaces the copy of that row
   assign w_copy_wr = w_copy && !(u_we && u_write_addr == r_sr);
   // rows below the sweep pointer already live in the next bank
   assign w_rbank   = (w_copy && u_read_addr < r_sr) ? w_nxt : r_bank;

   // controller next-state: sweep progress, request collapsing, timer and bank hand-over
   always_comb begin
      w_state_nx = r_state;
      w_sr_nx    = r_sr;
      w_tmr_nx   = r_tmr;
      w_pend_nx  = r_pend;
      w_bank_nx  = r_bank;
      w_done_nx  = 1'b0;
      if (w_copy) begin
         w_sr_nx   = w_last ? '0 : r_sr + 1'b1;
         w_pend_nx = r_pend | ref_req;
         if (w_last) begin
            w_state_nx = S_IDLE;
            w_bank_nx  = w_nxt;
            w_done_nx  = 1'b1;
         end
      end else if (w_start) begin
         w_state_nx = S_COPY;
         w_sr_nx    = '0;
         w_tmr_nx   = '0;
         w_pend_nx  = 1'b0;
      end else if (ref_auto_en) begin
         w_tmr_nx = r_tmr + 1'b1;
      end
   end

   // controller state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_sr    <= '0;
         r_tmr   <= '0;
         r_pend  <= 1'b0;
         r_bank  <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_sr    <= w_sr_nx;
         r_tmr   <= w_tmr_nx;
         r_pend  <= w_pend_nx;
         r_bank  <= w_bank_nx;
         r_done  <= w_done_nx;
      end
   end

   // storage: sweep copy into the next bank plus user writes into active (and next while sweeping)
   always_ff @(posedge clk) begin
      if (w_copy_wr) r_mem[w_nxt][r_sr] <= r_mem[r_bank][r_sr];
      if (u_we) begin
         r_mem[r_bank][u_write_addr] <= u_data_in;
         if (w_copy) r_mem[w_nxt][u_write_addr] <= u_data_in;
      end
   end

   // registered read port, holding data between reads
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rd       <= '0;
         r_rd_valid <= 1'b0;
      end else begin
         r_rd_valid <= u_re;
         if (u_re) r_rd <= r_mem[w_rbank][u_read_addr];
      end
   end

   assign rd          = r_rd;
   assign rd_valid    = r_rd_valid;
   assign ref_busy    = w_copy;
   assign ref_done    = r_done;
   assign active_bank = r_bank;
   assign sr_addr     = r_sr;
endmodule

// File: tb/tb_gc_rotating_refresh_bank.sv
// tb_gc_rotating_refresh_bank: vector table, directed sweep scenarios and random traffic against a logical-memory model
module tb_gc_rotating_refresh_bank;
   localparam int DW  = 64;
   localparam int DEP = 128;
   localparam int NB  = 3;
   localparam int RP  = 16;
   localparam int AW  = $clog2(DEP);
   localparam int BW  = $clog2(NB);

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          u_we = 1'b0, u_re = 1'b0, ref_auto_en = 1'b0, ref_req = 1'b0;
   logic [AW-1:0] u_write_addr = '0, u_read_addr = '0;
   logic [DW-1:0] u_data_in = '0;
   logic [DW-1:0] rd;
   logic          rd_valid, ref_busy, ref_done;
   logic [BW-1:0] active_bank;
   logic [AW-1:0] sr_addr;

   gc_rotating_refresh_bank #(.DATA_W(DW), .DEPTH(DEP), .NUM_BANKS(NB), .REF_PERIOD(RP)) dut (
      .clk(clk), .rst(rst), .u_we(u_we), .u_write_addr(u_write_addr), .u_data_in(u_data_in),
      .u_re(u_re), .u_read_addr(u_read_addr), .ref_auto_en(ref_auto_en), .ref_req(ref_req),
      .rd(rd), .rd_valid(rd_valid), .ref_busy(ref_busy), .ref_done(ref_done),
      .active_bank(active_bank), .sr_addr(sr_addr)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // logical single-memory view plus sweep schedule
   logic [DW-1:0] m_mem [DEP];
   bit            m_known [DEP];
   logic [DW-1:0] m_rd;
   bit            m_rd_known, m_valid, m_pend, m_done;
   int            m_left, m_tmr, m_active;

   typedef struct {
      bit            we;
      int            wa;
      logic [DW-1:0] wd;
      bit            re;
      int            ra;
      bit            ev;
      logic [DW-1:0] erd;
   } vec_t;
   vec_t vt [8];

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < DEP; i++) m_known[i] = 0;
      m_rd = '0; m_rd_known = 1; m_valid = 0;
      m_left = 0; m_tmr = 0; m_pend = 0; m_done = 0; m_active = 0;
   endtask

   task automatic step(input bit we, input int wa, input logic [DW-1:0] wd, input bit re, input int ra, input bit req);
      u_we = we; u_write_addr = AW'(wa); u_data_in = wd;
      u_re = re; u_read_addr = AW'(ra); ref_req = req;
      @(posedge clk);
      m_valid = re;
      if (re) begin
         m_rd_known = m_known[ra];
         m_rd = m_mem[ra];
      end
      if (we) begin
         m_mem[wa] = wd;
         m_known[wa] = 1;
      end
      m_done = 0;
      if (m_left > 0) begin
         if (req) m_pend = 1;
         m_left--;
         if (m_left == 0) begin
            m_active = (m_active + 1) % NB;
            m_done = 1;
         end
      end else if ((ref_auto_en && m_tmr == RP - 1) || req || m_pend) begin
         m_left = DEP; m_tmr = 0; m_pend = 0;
      end else if (ref_auto_en) begin
         m_tmr++;
      end
      #1;
      chk("rd_valid", rd_valid, m_valid);
      if (m_rd_known) chk("rd", rd, m_rd);
      chk("ref_busy", ref_busy, m_left > 0);
      chk("sr_addr", sr_addr, m_left > 0 ? DEP - m_left : 0);
      chk("ref_done", ref_done, m_done);
      chk("active_bank", active_bank, m_active);
      u_we = 0; u_re = 0; ref_req = 0;
   endtask

   task automatic idle();
      step(0, 0, '0, 0, 0, 0);
   endtask

   task automatic wait_done();
      int n = 0;
      do begin
         idle();
         n++;
      end while (!ref_done && n < 300);
      chk("done_timeout", ref_done, 1);
   endtask

   task automatic wait_sr(input int a);
      int n = 0;
      while (sr_addr != AW'(a) && n < 300) begin
         idle();
         n++;
      end
      chk("reach_sr", sr_addr, a);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_rd", rd, 0);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_busy", ref_busy, 0);
      chk("rst_done", ref_done, 0);
      chk("rst_active", active_bank, 0);
      chk("rst_sr", sr_addr, 0);
      @(negedge clk) rst = 1'b1;

      vt[0] = '{1, 5, 11, 0, 0, 0, 0};
      vt[1] = '{1, 6, 22, 0, 0, 0, 0};
      vt[2] = '{0, 0, 0,  1, 5, 1, 11};
      vt[3] = '{1, 6, 33, 1, 6, 1, 22};
      vt[4] = '{0, 0, 0,  1, 6, 1, 33};
      vt[5] = '{0, 0, 0,  0, 0, 0, 33};
      vt[6] = '{1, 5, 44, 1, 5, 1, 11};
      vt[7] = '{1, 7, 55, 1, 5, 1, 44};
      for (int i = 0; i < 8; i++) begin
         step(vt[i].we, vt[i].wa, vt[i].wd, vt[i].re, vt[i].ra, 0);
         chk("vec_valid", rd_valid, vt[i].ev);
         chk("vec_rd", rd, vt[i].erd);
      end

      for (int i = 0; i < DEP; i++) step(1, i, DW'(900 + i), 0, 0, 0);
      step(0, 0, '0, 0, 0, 1);
      repeat (DEP) idle();
      chk("first_done", ref_done, 1);
      chk("first_active", active_bank, 1);
      for (int i = 0; i < DEP; i++) begin
         step(0, 0, '0, 1, i, 0);
         chk("fill_rd", rd, 900 + i);
      end

      for (int k = 0; k < 3; k++) begin
         step(0, 0, '0, 0, 0, 1);
         repeat (DEP) idle();
         chk("rot_active", active_bank, (k + 2) % NB);
      end
      step(0, 0, '0, 1, 37, 0);
      chk("row37", rd, 937);

      step(1, 120, 5, 0, 0, 0);
      step(0, 0, '0, 0, 0, 1);
      wait_sr(50);
      step(1, 100, 2600, 1, 20, 0);
      chk("swept_read", rd, 920);
      step(1, 20, 7, 1, 120, 0);
      chk("unswept_read", rd, 5);
      step(1, 52, 4242, 0, 0, 0);
      wait_done();
      step(0, 0, '0, 1, 100, 0); chk("row100", rd, 2600);
      step(0, 0, '0, 1, 20, 0);  chk("row20", rd, 7);
      step(0, 0, '0, 1, 52, 0);  chk("row52", rd, 4242);
      step(0, 0, '0, 1, 120, 0); chk("row120", rd, 5);

      step(0, 0, '0, 0, 0, 1);
      wait_sr(10);
      step(0, 0, '0, 0, 0, 1);
      wait_sr(90);
      step(0, 0, '0, 0, 0, 1);
      wait_done();
      idle();
      chk("pend_restart_busy", ref_busy, 1);
      chk("pend_restart_sr", sr_addr, 0);
      wait_done();
      for (int i = 0; i < 5; i++) begin
         idle();
         chk("single_extra", ref_busy, 0);
      end

      ref_auto_en = 1'b1;
      step(0, 0, '0, 0, 0, 1);
      wait_done();
      for (int i = 0; i < RP; i++) begin
         idle();
         chk("auto_start", ref_busy, i == RP - 1);
      end
      ref_auto_en = 1'b0;
      wait_done();

      for (int i = 0; i < 2500; i++)
         step($urandom_range(0, 1), $urandom_range(0, DEP - 1), {$urandom, $urandom},
              $urandom_range(0, 1), $urandom_range(0, DEP - 1), $urandom_range(0, 39) == 0);
      for (int n = 0; n < 400 && (m_left > 0 || m_pend); n++) idle();
      chk("rand_settle", ref_busy, 0);

      step(1, 3, 77, 0, 0, 1);
      wait_sr(60);
      @(negedge clk) rst = 1'b0;
      #1;
      chk("abort_busy", ref_busy, 0);
      chk("abort_active", active_bank, 0);
      chk("abort_sr", sr_addr, 0);
      chk("abort_done", ref_done, 0);
      chk("abort_rd_valid", rd_valid, 0);
      chk("abort_rd", rd, 0);
      model_reset();
      @(posedge clk);
      @(negedge clk) rst = 1'b1;
      repeat (20) idle();
      step(1, 9, 123, 0, 0, 0);
      step(0, 0, '0, 1, 9, 0);
      chk("post_rst_rd", rd, 123);
      step(0, 0, '0, 0, 0, 1);
      wait_done();
      chk("post_rst_active", active_bank, 1);
      step(0, 0, '0, 1, 9, 0);
      chk("post_rst_swept", rd, 123);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
